// File: rtl/uop_cache_ctrl.sv
// uop_cache_ctrl: captures a loop body of micro-ops into the cache block RAM, then
// replays it a programmed number of times through a 2-entry output buffer that
// hides the cache's 1-cycle read latency.
module uop_cache_ctrl #(
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ITER_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DEPTH_LOG2:0]   loop_len,
  input  logic [ITER_W-1:0]     iterations,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_uop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_uop,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  cache_wr_en,
  output logic [DEPTH_LOG2-1:0] cache_wr_addr,
  output logic [DATA_W-1:0]     cache_wr_data,
  output logic                  cache_rd_en,
  output logic [DEPTH_LOG2-1:0] cache_rd_addr,
  input  logic [DATA_W-1:0]     cache_rd_data
);

  typedef enum logic [1:0] {StIdle, StFill, StReplay, StDrain} state_e;

  localparam logic [DEPTH_LOG2:0] MaxLen = {1'b1, {DEPTH_LOG2{1'b0}}};

  state_e                  state_q;
  logic [DEPTH_LOG2:0]     len_q;
  logic [ITER_W-1:0]       iter_q;
  logic [DEPTH_LOG2-1:0]   fill_ptr_q;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q;
  logic [ITER_W-1:0]       iter_cnt_q;
  logic [DATA_W-1:0]       obuf_q [2];
  logic                    head_q;
  logic [1:0]              occ_q;
  logic                    inflight_q;
  logic                    done_q;
  logic                    err_q;

  logic                    fill_hs;
  logic                    pop;
  logic [2:0]              slots_used;
  logic                    rd_issue;
  logic                    fill_last;
  logic                    rd_body_end;
  logic                    rd_last;
  logic                    start_ok;
  logic                    wr_idx;
  logic                    drain_done;

  // Handshakes, read-issue throttle and end-of-body detection
  always_comb begin
    fill_hs     = (state_q == StFill) && in_valid;
    pop         = (occ_q != 2'd0) && out_ready;
    // Entries held or on their way once this cycle's pop is accounted for
    slots_used  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_issue    = (state_q == StReplay) && (slots_used < 3'd2);
    fill_last   = ({1'b0, fill_ptr_q} == len_q - 1'b1);
    rd_body_end = ({1'b0, rd_ptr_q} == len_q - 1'b1);
    rd_last     = rd_body_end && (iter_cnt_q == iter_q - 1'b1);
    start_ok    = (loop_len != '0) && (loop_len <= MaxLen);
    wr_idx      = head_q ^ occ_q[0];
    drain_done  = pop && (occ_q == 2'd1) && !inflight_q;
  end

  assign in_ready      = (state_q == StFill);
  assign busy          = (state_q != StIdle);
  assign out_valid     = (occ_q != 2'd0);
  assign out_uop       = obuf_q[head_q];
  assign done          = done_q;
  assign err           = err_q;
  assign cache_wr_en   = fill_hs;
  assign cache_wr_addr = fill_ptr_q;
  assign cache_wr_data = in_uop;
  assign cache_rd_en   = rd_issue;
  assign cache_rd_addr = rd_ptr_q;

  // Sequencer state, pointers, output buffer and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      iter_q     <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
      iter_cnt_q <= '0;
      for (int i = 0; i < 2; i++) obuf_q[i] <= '0;
      head_q     <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (abort) begin
      // Flush; read data still in flight is dropped because inflight_q clears
      state_q    <= StIdle;
      head_q     <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      inflight_q <= rd_issue;
      if (inflight_q) obuf_q[wr_idx] <= cache_rd_data;
      if (pop) head_q <= ~head_q;
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};

      case (state_q)
        StIdle: begin
          if (start) begin
            if (start_ok) begin
              len_q      <= loop_len;
              iter_q     <= iterations;
              fill_ptr_q <= '0;
              rd_ptr_q   <= '0;
              iter_cnt_q <= '0;
              state_q    <= StFill;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StFill: begin
          if (fill_hs) begin
            fill_ptr_q <= fill_ptr_q + 1'b1;
            if (fill_last) begin
              if (iter_q == '0) begin
                state_q <= StIdle;
                done_q  <= 1'b1;
              end else begin
                state_q <= StReplay;
              end
            end
          end
        end
        StReplay: begin
          if (rd_issue) begin
            if (rd_body_end) begin
              rd_ptr_q   <= '0;
              iter_cnt_q <= iter_cnt_q + 1'b1;
            end else begin
              rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (rd_last) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (drain_done) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uop_cache_ctrl.sv
// tb_uop_cache_ctrl: directed sessions with random data and random backpressure,
// checked against a queue of expected beats built from body x iterations.
module tb_uop_cache_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [6:0]  loop_len;
  logic [7:0]  iterations;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_uop;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_uop;
  logic        busy;
  logic        done;
  logic        err;
  logic        cache_wr_en;
  logic [5:0]  cache_wr_addr;
  logic [31:0] cache_wr_data;
  logic        cache_rd_en;
  logic [5:0]  cache_rd_addr;
  logic [31:0] cache_rd_data;

  uop_cache_ctrl #(
    .DEPTH_LOG2(6),
    .DATA_W    (32),
    .ITER_W    (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .loop_len     (loop_len),
    .iterations   (iterations),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_uop       (in_uop),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_uop      (out_uop),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .cache_wr_en  (cache_wr_en),
    .cache_wr_addr(cache_wr_addr),
    .cache_wr_data(cache_wr_data),
    .cache_rd_en  (cache_rd_en),
    .cache_rd_addr(cache_rd_addr),
    .cache_rd_data(cache_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache block RAM: synchronous write, 1-cycle read latency
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (cache_wr_en) mem[cache_wr_addr] <= cache_wr_data;
    if (cache_rd_en) cache_rd_data <= mem[cache_rd_addr];
  end

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] body [64];
  logic [31:0] exp_q [$];
  int          cur_len  = 1;
  int          rd_count = 0;
  int          beats    = 0;
  int          pending  = 0;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: beat order, read addresses, port exclusivity, buffering bound
  always @(negedge clk) begin
    if (reset || abort) begin
      exp_q.delete();
      pending = 0;
    end else begin
      if (cache_rd_en) begin
        check1("rd_wr_exclusive", cache_wr_en, 1'b0);
        checkw("rd_addr", 64'(cache_rd_addr), 64'(rd_count % cur_len));
        rd_count++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check1("extra_beat", out_valid, 1'b0);
        else checkw("out_uop", 64'(out_uop), 64'(exp_q.pop_front()));
        beats++;
      end
      pending = pending + int'(cache_rd_en) - int'(out_valid && out_ready);
      if (cache_rd_en || out_valid) check1("occupancy_le_2", pending <= 2, 1'b1);
    end
  end

  task automatic start_session(input int len, input int iter);
    cur_len  = len;
    rd_count = 0;
    beats    = 0;
    for (int i = 0; i < len; i++) body[i] = $urandom;
    exp_q.delete();
    for (int it = 0; it < iter; it++)
      for (int i = 0; i < len; i++) exp_q.push_back(body[i]);
    start      = 1'b1;
    loop_len   = 7'(len);
    iterations = 8'(iter);
    step();
    start = 1'b0;
    check1("busy_after_start", busy, 1'b1);
    check1("in_ready_after_start", in_ready, 1'b1);
    check1("no_err_good_start", err, 1'b0);
  endtask

  task automatic fill(input int len, input int iter, input bit poke);
    for (int i = 0; i < len; i++) begin
      in_valid = 1'b1;
      in_uop   = body[i];
      if (poke && i == 1) begin
        start      = 1'b1;
        loop_len   = 7'd3;
        iterations = 8'd9;
      end
      #1;
      check1("wr_en", cache_wr_en, 1'b1);
      checkw("wr_addr", 64'(cache_wr_addr), 64'(i));
      step();
      start = 1'b0;
      check1("no_err_fill", err, 1'b0);
      if (i < len - 1) check1("in_ready_fill", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    check1("in_ready_exit", in_ready, 1'b0);
    check1("done_after_fill", done, iter == 0);
    check1("busy_after_fill", busy, iter != 0);
  endtask

  task automatic replay(input int len, input int iter, input int ready_pct);
    bit fin = 1'b0;
    bit final_hs;
    for (int k = 0; k < len * iter * 6 + 20 && !fin; k++) begin
      if (k < 2) check1("no_early_valid", out_valid, 1'b0);
      else if (k == 2) check1("first_valid", out_valid, 1'b1);
      else if (ready_pct == 100) check1("gapless_stream", out_valid, 1'b1);
      out_ready = ($urandom_range(99) < ready_pct);
      #1;
      final_hs = out_valid && out_ready && (exp_q.size() == 1);
      step();
      check1("done_timing", done, final_hs);
      if (final_hs) fin = 1'b1;
    end
    if (!fin) check1("replay_timeout", done, 1'b1);
    check1("busy_falls_with_done", busy, 1'b0);
    checkw("beat_count", 64'(beats), 64'(len * iter));
    out_ready = 1'b0;
    step();
    check1("done_single_pulse", done, 1'b0);
  endtask

  task automatic bad_len(input int len);
    start      = 1'b1;
    loop_len   = 7'(len);
    iterations = 8'd3;
    step();
    start = 1'b0;
    check1("err_pulse", err, 1'b1);
    check1("bad_len_idle", busy, 1'b0);
    check1("bad_len_in_ready", in_ready, 1'b0);
    step();
    check1("err_one_cycle", err, 1'b0);
    check1("bad_len_still_idle", busy, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    loop_len   = '0;
    iterations = '0;
    abort      = 1'b0;
    in_valid   = 1'b0;
    in_uop     = '0;
    out_ready  = 1'b0;
    step();
    step();
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_err", err, 1'b0);
    check1("rst_wr_en", cache_wr_en, 1'b0);
    check1("rst_rd_en", cache_rd_en, 1'b0);
    checkw("rst_wr_addr", 64'(cache_wr_addr), 64'd0);
    checkw("rst_rd_addr", 64'(cache_rd_addr), 64'd0);
    checkw("rst_out_uop", 64'(out_uop), 64'd0);
    reset = 1'b0;
    step();

    bad_len(0);
    bad_len(65);

    // Basic full-throughput replay
    start_session(4, 3);
    fill(4, 3, 1'b0);
    replay(4, 3, 100);

    // Start during FILL must be ignored
    start_session(6, 2);
    fill(6, 2, 1'b1);
    replay(6, 2, 80);

    // Full-depth body under random backpressure
    start_session(64, 2);
    fill(64, 2, 1'b0);
    replay(64, 2, 50);

    // Single-entry body, maximum iterations
    start_session(1, 255);
    fill(1, 255, 1'b0);
    replay(1, 255, 100);

    // Zero iterations: done straight out of FILL, nothing replayed
    start_session(5, 0);
    fill(5, 0, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check1("iter0_no_valid", out_valid, 1'b0);
      step();
      check1("iter0_no_done", done, 1'b0);
    end
    out_ready = 1'b0;

    // Abort with a full buffer and the consumer stalled
    start_session(4, 5);
    fill(4, 5, 1'b0);
    out_ready = 1'b0;
    step();
    step();
    step();
    check1("abort_pre_valid", out_valid, 1'b1);
    check1("abort_pre_stall", cache_rd_en, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check1("abort_out_valid", out_valid, 1'b0);
    check1("abort_busy", busy, 1'b0);
    check1("abort_in_ready", in_ready, 1'b0);
    check1("abort_no_done", done, 1'b0);
    step();
    check1("abort_no_done_late", done, 1'b0);
    check1("abort_stays_empty", out_valid, 1'b0);
    start_session(2, 1);
    fill(2, 1, 1'b0);
    replay(2, 1, 100);

    // Reset part-way through a fill, then refill from address 0
    start_session(8, 1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_uop   = body[i];
      step();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    check1("midrst_in_ready", in_ready, 1'b0);
    check1("midrst_out_valid", out_valid, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_done", done, 1'b0);
    check1("midrst_wr_en", cache_wr_en, 1'b0);
    checkw("midrst_wr_addr", 64'(cache_wr_addr), 64'd0);
    checkw("midrst_out_uop", 64'(out_uop), 64'd0);
    step();
    start_session(3, 2);
    fill(3, 2, 1'b0);
    replay(3, 2, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/uop_cache_ctrl.md
# uop_cache_ctrl

Sequencer for the 64-entry × 32-bit micro-op cache block RAM. It captures a loop body of micro-ops from the decode stream into the cache, then replays that body a programmed number of times to the issue stage over a valid/ready handshake. It owns both cache ports and hides the cache's 1-cycle read latency behind a 2-entry output buffer, so replay runs at full throughput under backpressure.

## Interface
- DEPTH_LOG2, 6: cache address width; depth = 2^DEPTH_LOG2.
- DATA_W, 32: micro-op width.
- ITER_W, 8: width of the iteration count.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  session request; sampled only in IDLE.
- loop_len  in  DEPTH_LOG2+1  body length; valid range 1..2^DEPTH_LOG2; sampled with start.
- iterations  in  ITER_W  replay count; sampled with start.
- abort  in  1  terminate the session.
- in_valid / in_ready / in_uop  in / out / in  1 / 1 / DATA_W  fill stream from decode.
- out_valid / out_ready / out_uop  out / in / out  1 / 1 / DATA_W  replay stream to issue.
- busy  out  1  high in any state other than IDLE.
- done  out  1  1-cycle pulse at normal completion.
- err  out  1  1-cycle pulse when start is rejected.
- cache_wr_en, cache_wr_addr, cache_wr_data  out  1, DEPTH_LOG2, DATA_W  cache write port.
- cache_rd_en, cache_rd_addr  out  1, DEPTH_LOG2  cache read port.
- cache_rd_data  in  DATA_W  cache read data, valid 1 cycle after cache_rd_en.

## Operation
- **States:** IDLE, FILL, REPLAY, DRAIN.
- **IDLE, start with valid loop_len:**
  - Latch len and iter.
  - Clear fill_ptr, rd_ptr and iter_cnt.
  - Go to FILL.
- **IDLE, start with loop_len = 0 or > 2^DEPTH_LOG2:** pulse err next cycle; stay in IDLE.
- **start outside IDLE:** ignored.
- **FILL:**
  - in_ready = 1.
  - cache_wr_en = in_valid & in_ready (combinational), cache_wr_addr = fill_ptr, cache_wr_data = in_uop.
  - Each handshake increments fill_ptr.
  - On the len-th handshake: if iter = 0, go to IDLE and pulse done; otherwise go to REPLAY.
- **REPLAY:**
  - Issue a read (cache_rd_en = 1, cache_rd_addr = rd_ptr) when occ + inflight − (out_valid & out_ready) < 2.
    - occ: buffer entries, 0..2.
    - inflight: reads issued last cycle, 0..1.
  - Each issued read advances rd_ptr.
  - rd_ptr wraps from len−1 to 0; each wrap increments iter_cnt.
  - After the read with iter_cnt = iter−1 and rd_ptr = len−1 is issued, go to DRAIN.
- **Output buffer:**
  - cache_rd_data is written into the buffer in the cycle after its read.
  - out_valid = (occ ≠ 0); out_uop = buffer head.
  - Order is strictly preserved; no drops, no duplicates.
- **DRAIN:** no reads; when the last buffered entry is accepted, go to IDLE and pulse done.
- **Beat count:** total out beats = len × iter (at most 64 × 255).
- **abort** (any state, priority over start):
  - Next cycle: IDLE, buffer flushed, in-flight read data discarded.
  - out_valid, in_ready and busy all 0.
  - No done pulse.
- **Cache contents:** never cleared by reset or abort.

## Timing
- **Reset values:**
  - IDLE.
  - in_ready, out_valid, busy, done, err, cache_wr_en, cache_rd_en = 0.
  - All addresses and pointers = 0.
  - out_uop = 0.
- **FILL entry:** in_ready high 1 cycle after the accepted start.
- **FILL exit:** in_ready low the cycle after the len-th handshake.
- **Collision avoidance:**
  - The first REPLAY read is issued the cycle after the last write, so no same-address write/read collision can occur.
  - cache_wr_en and cache_rd_en are never high in the same cycle.
- **Read-to-output latency:**
  - Read issued in cycle T, data on cache_rd_data in T+1, out_valid in T+2.
  - First out_valid comes 2 cycles after entering REPLAY.
- **Throughput:** one beat per cycle sustained while out_ready = 1.
- **Backpressure:** with out_ready = 0, at most 2 entries are buffered plus 0 in flight; reads stall.
- **done:** asserted the cycle after the final out handshake (or after the final fill handshake when iter = 0).
- **Reset mid-session:** same effect as abort, plus all outputs go to their reset values.

## Test plan
- **Basic:** start len=4, iter=3; fill A0..A3 back-to-back; out_ready=1.
  - Output is A0,A1,A2,A3 ×3: 12 beats on consecutive cycles, first beat 2 cycles after REPLAY entry.
  - done pulses once; busy falls with done.
- **Backpressure:** len=64, iter=2, out_ready random at 50%; fill D0..D63.
  - Output is 128 beats in order D0..D63, D0..D63.
  - cache_rd_addr wraps 63→0.
  - Buffer occupancy never exceeds 2.
- **Edge lengths and counts:**
  - len=1, iter=255: 255 copies of the single uop.
  - len=5, iter=0: done 1 cycle after the 5th fill handshake; out_valid never asserted.
- **Abort in REPLAY:** assert abort with out_valid=1, out_ready=0, occ=2.
  - Next cycle: out_valid=0, busy=0, no done.
  - A new start len=2, iter=1 then replays correctly.
- **Bad length / ignored start:**
  - start with loop_len=0 or 65: err pulses for 1 cycle; state stays IDLE; in_ready stays 0.
  - start during FILL: ignored.
- **Reset mid-fill:** after 3 handshakes of len=8, assert reset.
  - All outputs at reset values.
  - The next session fills from address 0.
